viterbi_frame_ctrl: RTL and testbench
=====================================

# viterbi_frame_ctrl

Frame-level sequencer for the 4-state Viterbi decoder. Accepts coded symbols over a valid/ready handshake and paces the ACS/path-metric stage one trellis step per accepted symbol. After FRAME_LEN steps it picks the minimum-metric end state, drives the traceback unit's `sel_node`/`en_tbck` pair until `done_flag`, and then presents the decoded byte downstream over a valid/ready handshake. It sits between the symbol source, the ACS/survivor datapath and the traceback decoder.

## Interface
- `FRAME_LEN`, 8: trellis steps per frame. Fixed at 8 to match the 8-bit traceback output.
- `PM_W`, 6: path-metric width, unsigned.
- `TB_TIMEOUT`, 15: maximum cycles in TB before the frame is aborted. Range 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sym_valid`  in  1: upstream symbol valid.
- `sym_ready`  out  1: controller can accept a symbol.
- `acs_en`  out  1: ACS/survivor write strobe, one per accepted symbol.
- `step_idx`  out  3: trellis step index of the current accept, 0..7.
- `pm_clr`  out  1: clear path metrics to the frame start state.
- `pm_00`, `pm_01`, `pm_10`, `pm_11`  in  PM_W: current path metrics.
- `sel_node`  out  2: start state for traceback.
- `tb_en`  out  1: drives traceback `en_tbck`.
- `tb_done`  in  1: traceback `done_flag`.
- `tb_data`  in  8: traceback `data_out`.
- `out_valid`  out  1: decoded byte valid.
- `out_ready`  in  1: downstream accepts the byte.
- `out_data`  out  8: decoded byte.
- `out_err`  out  1: qualifies `out_data`. 1 = traceback timed out.
- `busy`  out  1: high in every state except IDLE.
- `frame_cnt`  out  16: number of frames delivered. Wraps from 0xFFFF to 0.

## Operation
- FSM states and transitions:
  - IDLE → ACQ unconditionally after one cycle.
  - ACQ → SEL on the FRAME_LEN-th accept.
  - SEL → TB after one cycle.
  - TB → OUT on `tb_done`, or when the timeout expires.
  - OUT → IDLE on `out_valid & out_ready`.
- IDLE:
  - `pm_clr`=1, `sym_ready`=0, `tb_en`=0.
  - Step counter cleared to 0.
- ACQ:
  - `sym_ready`=1.
  - Accept = `sym_valid & sym_ready`.
  - `acs_en` = accept (combinational).
  - `step_idx` = step counter; the counter increments on each accept.
  - Accept at step 7 → SEL, counter wraps to 0.
- SEL:
  - Register `sel_node` = index of the minimum of pm_00..pm_11, compared unsigned.
  - Ties resolve to the lowest index (00 < 01 < 10 < 11).
  - `tb_en`=0 in this cycle, so the traceback unit loads `sel_node`.
- TB:
  - `tb_en`=1 and `sel_node` held stable.
  - A wait counter counts cycles spent in TB.
  - On `tb_done`=1: capture `tb_data` into `out_data`, `out_err`=0, `tb_en`=0 from the next cycle, go to OUT.
  - If the wait counter reaches TB_TIMEOUT without `tb_done`: `out_data`=0x00, `out_err`=1, go to OUT.
  - `tb_done` in the same cycle as the timeout: `tb_done` wins.
- OUT:
  - `out_valid`=1. `out_data` and `out_err` held until the handshake.
  - On handshake: increment `frame_cnt` (mod 2^16), go to IDLE.
- `sym_valid` outside ACQ is ignored: no accept, no `acs_en`.
- `tb_done` outside TB is ignored.
- `out_ready` without `out_valid` has no effect.
- Reset, asynchronous and valid in any state:
  - State = IDLE.
  - `sym_ready`=0, `acs_en`=0, `step_idx`=0, `pm_clr`=1 (IDLE), `sel_node`=00, `tb_en`=0.
  - `out_valid`=0, `out_data`=0x00, `out_err`=0, `busy`=0, `frame_cnt`=0.
  - A partial frame in progress at reset is discarded.

## Timing
- All state, counters and registered outputs update on the rising edge of `clk`.
- `acs_en` is combinational from `sym_valid`. All other outputs are registered or decoded from state.
- After reset release: one IDLE cycle, then `sym_ready`=1.
- With `sym_valid` held high, ACQ takes exactly 8 cycles.
- SEL is 1 cycle.
- TB lasts k cycles, where k = cycles until `tb_done` (≤ TB_TIMEOUT).
- `out_valid` rises the cycle after `tb_done` is sampled.
- Best-case frame period with `out_ready`=1: 1 (IDLE) + 8 + 1 + k + 1 cycles.
- `pm_00`..`pm_11` are sampled at the SEL edge and must reflect all 8 ACS updates by then.

## Test plan
- Reset, then 8 back-to-back symbols (`sym_valid`=1):
  - `acs_en` pulses 8 times with `step_idx` 0..7.
  - `sym_ready` drops after the 8th accept.
  - `pm_clr` high only in IDLE.
- Metrics pm = {9, 3, 3, 7} at SEL → `sel_node`=01 (tie to lowest index). `tb_en` low in SEL and high the next cycle.
- Traceback model asserts `tb_done` with `tb_data`=0xA5 after 9 cycles of `tb_en`:
  - `out_valid`=1, `out_data`=0xA5, `out_err`=0.
  - `frame_cnt` increments to 1 on the handshake.
- `tb_done` never asserted, TB_TIMEOUT=15:
  - `tb_en` high exactly 15 cycles.
  - Then `out_valid`=1, `out_data`=0x00, `out_err`=1.
- Backpressure:
  - `out_ready`=0 for 5 cycles: `out_data` stable and `sym_ready`=0 throughout.
  - `sym_valid` gaps in ACQ: no `acs_en`, `step_idx` holds.
- `rst` pulsed after the 4th accept → all outputs at reset values. The next frame restarts at `step_idx`=0 and `frame_cnt` stays 0.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the 4-state Viterbi decoder: paces ACS steps, selects the
// minimum-metric end state, runs traceback with a timeout and hands off the decoded byte.
module viterbi_frame_ctrl #(
   parameter int unsigned FRAME_LEN  = 8,
   parameter int unsigned PM_W       = 6,
   parameter int unsigned TB_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sym_valid,
   output logic            sym_ready,
   output logic            acs_en,
   output logic [2:0]      step_idx,
   output logic            pm_clr,
   input  logic [PM_W-1:0] pm_00,
   input  logic [PM_W-1:0] pm_01,
   input  logic [PM_W-1:0] pm_10,
   input  logic [PM_W-1:0] pm_11,
   output logic [1:0]      sel_node,
   output logic            tb_en,
   input  logic            tb_done,
   input  logic [7:0]      tb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [7:0]      out_data,
   output logic            out_err,
   output logic            busy,
   output logic [15:0]     frame_cnt
);

   typedef enum logic [2:0] {StIdle, StAcq, StSel, StTb, StOut} state_e;

   state_e          state_q, state_d;
   logic [2:0]      step_q, step_d;
   logic [7:0]      wait_q, wait_d;
   logic [1:0]      sel_q, sel_d;
   logic [7:0]      data_q, data_d;
   logic            err_q, err_d;
   logic [15:0]     cnt_q, cnt_d;
   logic [1:0]      min_idx;
   logic [PM_W-1:0] min_pm;

   // Strict less-than keeps ties on the lowest index.
   always_comb begin
      min_idx = 2'd0;
      min_pm  = pm_00;
      if (pm_01 < min_pm) begin
         min_idx = 2'd1;
         min_pm  = pm_01;
      end
      if (pm_10 < min_pm) begin
         min_idx = 2'd2;
         min_pm  = pm_10;
      end
      if (pm_11 < min_pm) begin
         min_idx = 2'd3;
         min_pm  = pm_11;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      wait_d  = wait_q;
      sel_d   = sel_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            step_d  = 3'd0;
            state_d = StAcq;
         end
         StAcq: begin
            if (sym_valid) begin
               if (step_q == 3'(FRAME_LEN - 1)) begin
                  step_d  = 3'd0;
                  state_d = StSel;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         StSel: begin
            sel_d   = min_idx;
            wait_d  = 8'd0;
            state_d = StTb;
         end
         StTb: begin
            // tb_done takes priority over a coincident timeout.
            if (tb_done) begin
               data_d  = tb_data;
               err_d   = 1'b0;
               state_d = StOut;
            end else if (wait_q == 8'(TB_TIMEOUT - 1)) begin
               data_d  = 8'h00;
               err_d   = 1'b1;
               state_d = StOut;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         StOut: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         step_q  <= 3'd0;
         wait_q  <= 8'd0;
         sel_q   <= 2'd0;
         data_q  <= 8'h00;
         err_q   <= 1'b0;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         wait_q  <= wait_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sym_ready = (state_q == StAcq);
   assign acs_en    = sym_valid & sym_ready;
   assign step_idx  = step_q;
   assign pm_clr    = (state_q == StIdle);
   assign sel_node  = sel_q;
   assign tb_en     = (state_q == StTb);
   assign out_valid = (state_q == StOut);
   assign out_data  = data_q;
   assign out_err   = err_q;
   assign busy      = (state_q != StIdle);
   assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: table-driven frames, a mid-frame reset and random frames
// checked against a small frame-level reference model.
module tb_viterbi_frame_ctrl;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        sym_valid, sym_ready, acs_en, pm_clr, tb_en, tb_done;
   logic [2:0]  step_idx;
   logic [5:0]  pm_00, pm_01, pm_10, pm_11;
   logic [1:0]  sel_node;
   logic [7:0]  tb_data, out_data;
   logic        out_valid, out_ready, out_err, busy;
   logic [15:0] frame_cnt;

   int checks = 0;
   int errors = 0;
   int exp_frames = 0;

   typedef struct packed {
      logic [5:0] p0, p1, p2, p3;
      int         done_after;  // tb_en cycle on which tb_done rises; outside 1..TO = never
      logic [7:0] data;
      int         ready_delay;
      int         gap_pct;
      logic [1:0] exp_sel;
      logic [7:0] exp_data;
      logic       exp_err;
      int         exp_tb;
   } vec_t;

   viterbi_frame_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .acs_en    (acs_en),
      .step_idx  (step_idx),
      .pm_clr    (pm_clr),
      .pm_00     (pm_00),
      .pm_01     (pm_01),
      .pm_10     (pm_10),
      .pm_11     (pm_11),
      .sel_node  (sel_node),
      .tb_en     (tb_en),
      .tb_done   (tb_done),
      .tb_data   (tb_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: minimum value first, then the first index holding it.
   function automatic vec_t ref_model(input vec_t v);
      int   vals[4];
      int   mn;
      vec_t r;
      r = v;
      vals[0] = int'(v.p0); vals[1] = int'(v.p1); vals[2] = int'(v.p2); vals[3] = int'(v.p3);
      mn = vals[0];
      foreach (vals[i]) if (vals[i] < mn) mn = vals[i];
      r.exp_sel = 2'd3;
      for (int i = 3; i >= 0; i--) if (vals[i] == mn) r.exp_sel = 2'(i);
      r.exp_err  = !(v.done_after >= 1 && v.done_after <= TO);
      r.exp_tb   = r.exp_err ? TO : v.done_after;
      r.exp_data = r.exp_err ? 8'h00 : v.data;
      return r;
   endfunction

   task automatic junk_pm();
      pm_00 = 6'($urandom); pm_01 = 6'($urandom); pm_10 = 6'($urandom); pm_11 = 6'($urandom);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_sym_ready"}, sym_ready, 0);
      chk({tag, "_acs_en"}, acs_en, 0);
      chk({tag, "_step_idx"}, step_idx, 0);
      chk({tag, "_pm_clr"}, pm_clr, 1);
      chk({tag, "_sel_node"}, sel_node, 0);
      chk({tag, "_tb_en"}, tb_en, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_err"}, out_err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_cnt"}, frame_cnt, 0);
   endtask

   // Entered on a negedge where the DUT is in IDLE; leaves on the next IDLE negedge.
   task automatic run_frame(input vec_t v, input int abort_at);
      int accepts = 0;
      int cyc = 0;
      int n = 0;
      chk("idle_pm_clr", pm_clr, 1);
      chk("idle_busy", busy, 0);
      chk("idle_sym_ready", sym_ready, 0);
      chk("idle_tb_en", tb_en, 0);
      chk("idle_out_valid", out_valid, 0);
      junk_pm();
      sym_valid = 1'b1;
      #1 chk("idle_acs_en", acs_en, 0);
      while (accepts < 8) begin
         @(negedge clk);
         cyc++;
         if (cyc > 400) begin
            chk("acq_timeout", accepts, 8);
            return;
         end
         if (abort_at != 0 && accepts == abort_at) begin
            #2 rst = 1'b1;
            #1 reset_checks("abort");
            @(negedge clk);
            rst = 1'b0;
            exp_frames = 0;
            return;
         end
         chk("acq_sym_ready", sym_ready, 1);
         chk("acq_pm_clr", pm_clr, 0);
         chk("acq_busy", busy, 1);
         chk("acq_step_idx", step_idx, accepts);
         chk("acq_frame_cnt", frame_cnt, exp_frames);
         sym_valid = ($urandom_range(0, 99) >= v.gap_pct);
         tb_done   = 1'($urandom);
         tb_data   = 8'($urandom);
         out_ready = 1'($urandom);
         #1 chk("acq_acs_en", acs_en, sym_valid);
         if (sym_valid) accepts++;
      end
      if (v.gap_pct == 0) chk("acq_cycles", cyc, 8);
      @(negedge clk);  // SEL
      chk("sel_sym_ready", sym_ready, 0);
      chk("sel_tb_en", tb_en, 0);
      chk("sel_pm_clr", pm_clr, 0);
      sym_valid = 1'b1;
      tb_done   = 1'b0;
      pm_00 = v.p0; pm_01 = v.p1; pm_10 = v.p2; pm_11 = v.p3;
      #1 chk("sel_acs_en", acs_en, 0);
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (!tb_en) break;
         n++;
         junk_pm();
         chk("tb_sel_node", sel_node, v.exp_sel);
         chk("tb_sym_ready", sym_ready, 0);
         tb_done = (n == v.done_after);
         tb_data = tb_done ? v.data : 8'($urandom);
      end
      // OUT
      chk("tb_cycles", n, v.exp_tb);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, v.exp_data);
      chk("out_err", out_err, v.exp_err);
      tb_done   = 1'b1;
      tb_data   = 8'($urandom);
      out_ready = (v.ready_delay == 0);
      for (int d = 1; d <= v.ready_delay; d++) begin
         @(negedge clk);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_data", out_data, v.exp_data);
         chk("bp_out_err", out_err, v.exp_err);
         chk("bp_sym_ready", sym_ready, 0);
         chk("bp_frame_cnt", frame_cnt, exp_frames);
         tb_data   = 8'($urandom);
         out_ready = (d == v.ready_delay);
      end
      @(negedge clk);
      exp_frames++;
      chk("done_out_valid", out_valid, 0);
      chk("done_frame_cnt", frame_cnt, 16'(exp_frames));
      tb_done   = 1'b0;
      out_ready = 1'($urandom);
   endtask

   vec_t vecs[5];
   vec_t rv;

   initial begin
      // p0 p1 p2 p3, done_after, data, ready_delay, gap_pct, exp sel/data/err, exp tb cycles
      vecs[0] = '{6'd9, 6'd3, 6'd3, 6'd7, 9, 8'hA5, 0, 0, 2'd1, 8'hA5, 1'b0, 9};
      vecs[1] = '{6'd20, 6'd20, 6'd20, 6'd20, 0, 8'h5A, 5, 0, 2'd0, 8'h00, 1'b1, 15};
      vecs[2] = '{6'd63, 6'd62, 6'd1, 6'd1, 15, 8'h3C, 2, 40, 2'd2, 8'h3C, 1'b0, 15};
      vecs[3] = '{6'd5, 6'd6, 6'd7, 6'd0, 1, 8'hFF, 0, 30, 2'd3, 8'hFF, 1'b0, 1};
      vecs[4] = '{6'd0, 6'd0, 6'd63, 6'd63, 16, 8'h77, 1, 0, 2'd0, 8'h00, 1'b1, 15};

      rst = 1'b1;
      sym_valid = 1'b1; tb_done = 1'b1; tb_data = 8'hC3; out_ready = 1'b1;
      junk_pm();
      #1 reset_checks("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) run_frame(vecs[i], 0);

      run_frame(vecs[0], 4);
      run_frame(vecs[3], 0);

      for (int i = 0; i < 25; i++) begin
         rv = '0;
         rv.p0 = 6'($urandom); rv.p1 = 6'($urandom);
         rv.p2 = 6'($urandom); rv.p3 = 6'($urandom);
         if (i % 3 == 0) rv.p2 = rv.p1;
         rv.done_after  = $urandom_range(0, 18);
         rv.data        = 8'($urandom);
         rv.ready_delay = $urandom_range(0, 3);
         rv.gap_pct     = $urandom_range(0, 60);
         run_frame(ref_model(rv), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
